// File: rtl/data_split_pkg.sv
// ============================================================================
//  Module   : data_split_pkg
//  Brief    : Shared widths, mode encodings, FIFO entry layout and FSM states
//  Revision : 1.0
// ============================================================================
`default_nettype none

package data_split_pkg;

    localparam int DATA_W     = 8;
    localparam int NIB_W      = 4;
    localparam int FIFO_DEPTH = 2;

    localparam logic MODE_BYTE = 1'b1;
    localparam logic MODE_NIB  = 1'b0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LO   = 1'b1
    } state_t;

    // One FIFO slot: the mode travels with the byte it was sampled with.
    typedef struct packed {
        logic              mode;
        logic [DATA_W-1:0] data;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    function automatic logic [DATA_W-1:0] zext_nib(input logic [NIB_W-1:0] nib);
        return {{(DATA_W-NIB_W){1'b0}}, nib};
    endfunction

endpackage

`default_nettype wire

// File: rtl/data_split_fifo.sv
// ============================================================================
//  Module   : data_split_fifo
//  Brief    : Small in-order register FIFO with registered occupancy counter
//  Revision : 1.0
// ============================================================================
`default_nettype none

module data_split_fifo
    import data_split_pkg::*;
#(
    parameter int WIDTH = ENTRY_W,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic do_push;
    logic do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Requests against a full/empty FIFO are dropped rather than corrupting state.
    assign do_push = push && !full;
    assign do_pop  = pop  && !empty;

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/data_split.sv
// ============================================================================
//  Module   : data_split
//  Brief    : Buffers input bytes and re-emits each as one byte or two nibbles
//  Revision : 1.0
// ============================================================================
`default_nettype none

module data_split
    import data_split_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              din_vld,
    input  logic              byte_mode,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic [DATA_W-1:0] data_o,
    output logic              data_en
);

    state_t             state;
    state_t             state_nxt;
    logic [DATA_W-1:0]  data_nxt;
    logic               en_nxt;
    logic [NIB_W-1:0]   lo_nib;
    logic [NIB_W-1:0]   lo_nxt;

    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    entry_t             in_entry;
    entry_t             head;

    // Gating on reset_n keeps ready low for the whole reset window.
    assign ready    = reset_n && start && !full;
    assign push     = din_vld && ready;
    assign in_entry = {byte_mode, data_in};

    data_split_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (in_entry),
        .full    (full),
        .empty   (empty),
        .head    (head)
    );

    always_comb begin
        state_nxt = state;
        data_nxt  = data_o;
        en_nxt    = 1'b0;
        lo_nxt    = lo_nib;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop    = 1'b1;
                    en_nxt = 1'b1;
                    if (head.mode == MODE_BYTE) begin
                        data_nxt = head.data;
                    end else begin
                        data_nxt  = zext_nib(head.data[DATA_W-1:NIB_W]);
                        lo_nxt    = head.data[NIB_W-1:0];
                        state_nxt = LO;
                    end
                end
            end
            LO: begin
                // Low nibble goes out from the latch, so the FIFO can advance meanwhile.
                data_nxt  = zext_nib(lo_nib);
                en_nxt    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            data_o  <= '0;
            data_en <= 1'b0;
            lo_nib  <= '0;
        end else begin
            state   <= state_nxt;
            data_o  <= data_nxt;
            data_en <= en_nxt;
            lo_nib  <= lo_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_split.sv
// ============================================================================
//  Module   : tb_data_split
//  Brief    : Scoreboard bench for data_split with directed and random traffic
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_data_split;
    import data_split_pkg::*;

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b0;
    logic       start     = 1'b0;
    logic       din_vld   = 1'b0;
    logic       byte_mode = 1'b0;
    logic [7:0] data_in   = 8'h00;
    logic       ready;
    logic [7:0] data_o;
    logic       data_en;

    data_split dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .din_vld   (din_vld),
        .byte_mode (byte_mode),
        .data_in   (data_in),
        .ready     (ready),
        .data_o    (data_o),
        .data_en   (data_en)
    );

    always #5 clk = ~clk;

    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;
    int         n_out  = 0;
    logic [7:0] sbq[$];
    int         en_log[$];
    logic [7:0] mon_exp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest expected word.
    always @(posedge clk) begin
        #1;
        if (data_en === 1'b1) begin
            n_out++;
            en_log.push_back(cyc);
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0h expected none", data_o);
            end else begin
                mon_exp = sbq.pop_front();
                chk("data_o", {24'h0, data_o}, {24'h0, mon_exp});
            end
        end
    end

    // Reference model: a byte yields itself, a nibble-mode byte yields high then low nibble.
    task automatic model_accept(input logic [7:0] d, input logic m);
        if (m == MODE_BYTE) begin
            sbq.push_back(d);
        end else begin
            sbq.push_back({4'h0, d[7:4]});
            sbq.push_back({4'h0, d[3:0]});
        end
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic drive(input logic v, input logic m, input logic [7:0] d, output logic acc);
        din_vld   = v;
        byte_mode = m;
        data_in   = d;
        #1;
        acc = v && (ready === 1'b1);
        @(posedge clk);
        if (acc) model_accept(d, m);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic m, output int waits);
        logic acc;
        waits = 0;
        forever begin
            drive(1'b1, m, d, acc);
            if (acc) break;
            waits++;
            if (waits > 100) begin
                chk("send_timeout", 32'(waits), 0);
                break;
            end
        end
        din_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        logic acc;
        repeat (n) drive(1'b0, 1'b0, 8'h00, acc);
    endtask

    task automatic drain();
        int t = 0;
        din_vld = 1'b0;
        while (sbq.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain_empty", 32'(sbq.size()), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic consec(input string name, input int n);
        int sz = en_log.size();
        if (sz < n) chk(name, 32'(sz), 32'(n));
        else        chk(name, 32'(en_log[sz-1] - en_log[sz-n]), 32'(n - 1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int   w, w1, w2, wsum, n0;
        logic acc;

        // Reset behaviour
        reset_n = 1'b0;
        start   = 1'b1;
        repeat (3) @(negedge clk);
        chk("ready_in_reset", ready, 0);
        chk("en_in_reset", data_en, 0);
        chk("data_o_in_reset", data_o, 0);
        reset_n = 1'b1;
        #1;
        chk("ready_after_reset", ready, 1);
        @(negedge clk);

        // Single nibble-mode byte: latency and ordering
        send(8'h84, MODE_NIB, w);
        chk("lat_not_yet", data_en, 0);
        @(negedge clk);
        chk("nib_hi_en", data_en, 1);
        chk("nib_hi", data_o, 8'h08);
        @(negedge clk);
        chk("nib_lo_en", data_en, 1);
        chk("nib_lo", data_o, 8'h04);
        @(negedge clk);
        chk("nib_done_en", data_en, 0);
        chk("data_o_hold", data_o, 8'h04);

        // Back-to-back byte mode
        send(8'h21, MODE_BYTE, w1);
        send(8'h69, MODE_BYTE, w2);
        chk("b2b_ready_high", 32'(w1 + w2), 0);
        drain();
        consec("b2b_contig", 2);

        // Continuous nibble stream fills the FIFO
        n0   = n_out;
        wsum = 0;
        for (int i = 0; i < 8; i++) begin
            send(8'hA5, MODE_NIB, w);
            wsum += w;
        end
        chk("stream_ready_drop", 32'(wsum > 0), 1);
        drain();
        chk("stream_count", 32'(n_out - n0), 16);
        consec("stream_contig", 16);

        // Fill, then drop start: stored entries must still drain, nothing new accepted
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), acc);
            if (!acc) break;
        end
        start   = 1'b0;
        din_vld = 1'b1;
        #1;
        chk("stop_ready", ready, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("stop_ready_hold", ready, 0);
        end
        @(negedge clk);
        drain();
        start = 1'b1;

        // Reset while the low nibble is pending
        send(8'hA5, MODE_NIB, w);
        @(negedge clk);
        chk("pre_rst_hi", data_o, 8'h0A);
        reset_n = 1'b0;
        #1;
        chk("rst_async_data", data_o, 8'h00);
        chk("rst_async_en", data_en, 0);
        sbq.delete();
        n0 = n_out;
        repeat (3) @(negedge clk);
        chk("rst_ready_low", ready, 0);
        reset_n = 1'b1;
        idle(8);
        chk("no_out_after_rst", 32'(n_out - n0), 0);

        // Mixed modes, continuous output
        send(8'h84, MODE_NIB, w);
        send(8'h21, MODE_BYTE, w);
        send(8'h69, MODE_NIB, w);
        drain();
        consec("mixed_contig", 5);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            start = ($urandom_range(0, 9) != 0);
            drive($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)), acc);
        end
        start = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
